// File: rtl/hamming_serial_decoder.sv
// Bit-serial Hamming(7,4) receiver: collects a 7-bit codeword, corrects any single-bit
// error under even or odd parity, and holds the result on a valid/ready output.
module hamming_serial_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_clr,
  input  logic             parity_type,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [4:1]       data_out,
  output logic [7:1]       code_out,
  output logic [3:1]       parity_out,
  output logic             error_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] RECV  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:1]       rx_q, rx_d;
  logic [7:1]       code_q;
  logic [4:1]       data_q;
  logic [3:1]       par_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:1]       syn;
  logic [7:1]       fixed;

  assign ser_ready  = (state_q == RECV);
  assign out_valid  = (state_q == HOLD);
  assign data_out   = data_q;
  assign code_out   = code_q;
  assign parity_out = par_q;
  assign error_d    = err_q;
  assign err_cnt    = cnt_q;

  // Bits shift in from the top, so after seven accepts the first bit sits at position 1.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    case (state_q)
      RECV: begin
        if (frame_clr) begin
          bit_cnt_d = 3'd0;
        end else if (ser_valid) begin
          rx_d = {ser_in, rx_q[7:2]};
          if (bit_cnt_q == 3'd6) begin
            bit_cnt_d = 3'd0;
            state_d   = CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      CHECK:   state_d = HOLD;
      HOLD:    if (out_ready) state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  always_comb begin
    syn[1] = rx_q[1] ^ rx_q[3] ^ rx_q[5] ^ rx_q[7] ^ parity_type;
    syn[2] = rx_q[2] ^ rx_q[3] ^ rx_q[6] ^ rx_q[7] ^ parity_type;
    syn[3] = rx_q[4] ^ rx_q[5] ^ rx_q[6] ^ rx_q[7] ^ parity_type;
    fixed  = rx_q;
    for (int i = 1; i <= 7; i++) begin
      fixed[i] = rx_q[i] ^ (syn == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RECV;
      bit_cnt_q <= 3'd0;
      rx_q      <= '0;
      code_q    <= '0;
      data_q    <= '0;
      par_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      // Results are captured only on the single CHECK cycle and then held through HOLD.
      if (state_q == CHECK) begin
        code_q <= fixed;
        data_q <= {fixed[7], fixed[6], fixed[5], fixed[3]};
        par_q  <= syn;
        err_q  <= |syn;
        if ((|syn) && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Directed bench for hamming_serial_decoder with a scoreboard of expected decoded words.
module tb_hamming_serial_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_clr = 1'b0;
  logic       parity_type = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       ser_ready;
  logic [4:1] data_out;
  logic [7:1] code_out;
  logic [3:1] parity_out;
  logic       error_d;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] err_cnt;

  typedef struct {
    logic [7:1] code;
    logic [4:1] data;
    logic [3:1] par;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  logic [7:0] expCnt = 8'd0;

  hamming_serial_decoder #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_clr(frame_clr), .parity_type(parity_type),
    .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .data_out(data_out), .code_out(code_out), .parity_out(parity_out),
    .error_d(error_d), .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:1] encode(input logic [4:1] d, input logic odd);
    logic p1, p2, p4;
    p1 = d[1] ^ d[2] ^ d[4] ^ odd;
    p2 = d[1] ^ d[3] ^ d[4] ^ odd;
    p4 = d[2] ^ d[3] ^ d[4] ^ odd;
    return {d[4], d[3], d[2], p4, d[1], p2, p1};
  endfunction

  task automatic sendBit(input logic b);
    int guard = 0;
    @(negedge clk);
    ser_in    = b;
    ser_valid = 1'b1;
    while (!ser_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ser_ready wait", ser_ready, 1);
    @(posedge clk);
    #1 ser_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:1] rx, input logic ptype, input logic [7:1] eCode,
                               input logic [4:1] eData, input logic [3:1] ePar, input logic eErr,
                               input logic gap);
    exp_t e;
    parity_type = ptype;
    if (eErr) expCnt = (expCnt == 8'hFF) ? 8'hFF : expCnt + 8'd1;
    e.code = eCode; e.data = eData; e.par = ePar; e.err = eErr; e.cnt = expCnt;
    sb.push_back(e);
    for (int i = 1; i <= 7; i++) begin
      sendBit(rx[i]);
      if (gap && i == 3) repeat (2) @(negedge clk);
    end
  endtask

  task automatic checkOutput(input int holdCycles);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("out_valid wait", out_valid, 1);
    if (sb.size() > 0) e = sb.pop_front();
    check("data_out", data_out, e.data);
    check("code_out", code_out, e.code);
    check("parity_out", parity_out, e.par);
    check("error_d", error_d, e.err);
    check("err_cnt", err_cnt, e.cnt);
    check("ser_ready in HOLD", ser_ready, 0);
    repeat (holdCycles) begin
      @(negedge clk);
      check("out_valid held", out_valid, 1);
      check("ser_ready held", ser_ready, 0);
      check("code_out held", code_out, e.code);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("out_valid after hs", out_valid, 0);
    check("ser_ready after hs", ser_ready, 1);
  endtask

  initial begin
    logic [7:1] cw, rx;
    logic [4:1] d;
    logic       odd;
    int         pos;

    #1;
    check("reset data_out", data_out, 0);
    check("reset code_out", code_out, 0);
    check("reset parity_out", parity_out, 0);
    check("reset error_d", error_d, 0);
    check("reset out_valid", out_valid, 0);
    check("reset err_cnt", err_cnt, 0);
    check("reset ser_ready", ser_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Clean even frame with latency check: CHECK cycle after the 7th accept, then HOLD.
    applyStimulus(7'b0101101, 1'b0, 7'b0101101, 4'b0101, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    check("latency CHECK out_valid", out_valid, 0);
    check("latency CHECK ser_ready", ser_ready, 0);
    checkOutput(0);

    applyStimulus(7'b0111101, 1'b0, 7'b0101101, 4'b0101, 3'b101, 1'b1, 1'b0);
    checkOutput(1);

    applyStimulus(7'b0100110, 1'b1, 7'b0100110, 4'b0101, 3'b000, 1'b0, 1'b1);
    checkOutput(0);

    // Backpressure with the next frames already being offered during HOLD.
    applyStimulus(7'b1100111, 1'b0, 7'b1100110, 4'b1101, 3'b001, 1'b1, 1'b0);
    fork
      checkOutput(5);
      applyStimulus(7'b0000000, 1'b0, 7'b0000000, 4'b0000, 3'b000, 1'b0, 1'b0);
    join
    fork
      checkOutput(2);
      applyStimulus(7'b1010101, 1'b0, 7'b1010101, 4'b1011, 3'b000, 1'b0, 1'b0);
    join
    checkOutput(0);

    // Partial frame discarded by frame_clr; the bit offered alongside it must be ignored.
    sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
    @(negedge clk);
    frame_clr = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
    @(posedge clk);
    #1 frame_clr = 1'b0; ser_valid = 1'b0;
    applyStimulus(7'b0101101, 1'b0, 7'b0101101, 4'b0101, 3'b000, 1'b0, 1'b0);
    checkOutput(0);

    // Asynchronous reset while holding an errored word.
    applyStimulus(7'b0111101, 1'b0, 7'b0101101, 4'b0101, 3'b101, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre-reset out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid-HOLD reset data_out", data_out, 0);
    check("mid-HOLD reset code_out", code_out, 0);
    check("mid-HOLD reset parity_out", parity_out, 0);
    check("mid-HOLD reset error_d", error_d, 0);
    check("mid-HOLD reset out_valid", out_valid, 0);
    check("mid-HOLD reset err_cnt", err_cnt, 0);
    check("mid-HOLD reset ser_ready", ser_ready, 1);
    sb.delete();
    expCnt = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation: 260 single-error frames of random data, position and parity.
    for (int n = 0; n < 260; n++) begin
      d   = 4'($urandom_range(0, 15));
      odd = 1'($urandom_range(0, 1));
      pos = int'($urandom_range(1, 7));
      cw  = encode(d, odd);
      rx  = cw;
      rx[pos] = ~rx[pos];
      applyStimulus(rx, odd, cw, d, 3'(pos), 1'b1, 1'b0);
      checkOutput(0);
    end
    check("err_cnt saturated", err_cnt, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hamming_serial_decoder.md
# hamming_serial_decoder

- Receive-side Hamming(7,4) block: accepts 7-bit codewords bit-serially over a valid/ready link.
- Computes the 3-bit syndrome under a selectable even/odd parity convention, corrects any single-bit error, and presents the 4-bit data word on a valid/ready output.
- Sits at the far end of the serial link fed by the Hamming encoder; maintains a saturating count of corrected errors for status readout.

## Interface
- `CNT_W`, 8, width of the corrected-error counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_clr` in 1: synchronous; discards any partial frame.
- `parity_type` in 1: 0 = even parity, 1 = odd parity.
- `ser_in` in 1: serial code bit.
- `ser_valid` in 1: `ser_in` is valid.
- `ser_ready` out 1: decoder accepts a bit this cycle.
- `data_out` out [4:1]: corrected data.
- `code_out` out [7:1]: corrected codeword.
- `parity_out` out [3:1]: syndrome {s3,s2,s1}.
- `error_d` out 1: syndrome was non-zero.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer accepts the word.
- `err_cnt` out [CNT_W-1:0]: saturating count of frames with `error_d`=1.

## Operation
**FSM states:** RECV, CHECK, HOLD.
- Reset state is RECV.
- **RECV**
  - `ser_ready`=1.
  - A bit is accepted on an edge where `ser_valid`=1; it is stored at code position `bit_cnt`+1.
  - Bits arrive position 1 first and position 7 last.
  - `bit_cnt` is 3 bits and runs 0..6.
  - Accepting the bit at `bit_cnt`=6 sets `bit_cnt` to 0 and moves to CHECK.
- **CHECK** (exactly one cycle)
  - `ser_ready`=0.
  - `parity_type` is sampled here.
  - Syndrome bits, with ^ = XOR over the received code positions:
    - s1 = ^{1,3,5,7}
    - s2 = ^{2,3,6,7}
    - s3 = ^{4,5,6,7}
  - For odd parity, each syndrome bit is inverted.
  - If the syndrome S is non-zero, code bit S is flipped.
  - Registered on exit:
    - `code_out`
    - `data_out` = {c7,c6,c5,c3}
    - `parity_out` = S
    - `error_d` = (S≠0)
  - `err_cnt` increments (saturating at all-ones) when S≠0.
  - Next state is HOLD.
- **HOLD**
  - `out_valid`=1 and `ser_ready`=0.
  - All outputs are held stable until `out_valid`&`out_ready` on an edge, then the FSM returns to RECV.
- **`frame_clr`**
  - Asserted in RECV: `bit_cnt` is set to 0 and no bit is accepted that cycle.
  - Asserted in CHECK: ignored.
  - Asserted in HOLD: ignored.
- **Double-bit errors** are not detected; the block miscorrects as the Hamming syndrome dictates. This is accepted behaviour.
- **Reset values**
  - Every output register is 0: `data_out`, `code_out`, `parity_out`, `error_d`, `out_valid`, `err_cnt`.
  - `bit_cnt`=0.
  - `ser_ready`=1 after reset; it is a combinational decode of the RECV state.

## Timing
- **Latency:** 7th bit accepted at edge E; CHECK occupies the cycle after E; `out_valid` goes high after edge E+1.
- **Throughput:** one codeword per 7 accept cycles + 1 CHECK cycle + ≥1 HOLD cycle.
- **Back-to-back consumption:**
  - With `out_ready`=1 continuously, HOLD lasts 1 cycle.
  - `ser_ready` returns high the cycle after the handshake edge.
- **Backpressure:** `out_ready` low holds HOLD indefinitely; `ser_ready` stays 0, so no bits are lost.
- **Gaps:** `ser_valid` gaps in RECV stall `bit_cnt`; partial frames persist across gaps.
- **Asynchronous reset** (asserted mid-frame or in HOLD):
  - Outputs clear immediately.
  - The partial frame is lost.
  - The FSM restarts in RECV on release.
- **Independence:** `ser_ready` depends only on state, never on `ser_valid`.

## Test plan
- **Clean frame, even parity:** serial 1,0,1,1,0,1,0 (code[7:1]=0101101), `parity_type`=0 → `data_out`=0101, `parity_out`=000, `error_d`=0, `out_valid` after edge E+1.
- **Single-bit error, even parity:** position 5 flipped (code 0111101) → `parity_out`=101, `code_out`=0101101, `data_out`=0101, `error_d`=1, `err_cnt`=1.
- **Odd parity:** data 0101, code[7:1]=0100110, `parity_type`=1 → `error_d`=0, `data_out`=0101.
- **Back-to-back frames with stalls:**
  - Stimulus: data 1101 even (code 1100110 with position 1 flipped → 1100111), `out_ready` held low 5 cycles, then a second frame of 0000 (code 0000000) queued.
  - Required: `parity_out`=001, `data_out`=1101, `ser_ready`=0 throughout HOLD, second frame → 0000, no bit dropped.
- **Aborts and reset:** `frame_clr` after 3 bits, then a full clean frame → decodes correctly; `rst_n` low mid-HOLD → all outputs 0, `err_cnt`=0.
- **Counter saturation:** 260 erroneous frames with `CNT_W`=8 → `err_cnt`=255, no wrap.
